// File: rtl/classifier_sched_pkg.sv
// Shared types and constants for the classifier scheduler.
// Holds the FSM state enum, datapath widths and the saturating counter helper.
package classifier_sched_pkg;

   localparam int FEATURE_W = 16;
   localparam int DET_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      STREAM,
      DRAIN,
      WAIT,
      REPORT
   } sched_state_t;

   function automatic logic [DET_CNT_W-1:0] sat_inc(input logic [DET_CNT_W-1:0] value);
      return (value == '1) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/classifier_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer.
module rr_arbiter
   import classifier_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_in,
   input  logic [ID_W-1:0]    ptr_in,
   output logic [ID_W-1:0]    grant_id_out,
   output logic               any_out
);

   function automatic logic [ID_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
      int unsigned sum;
      sum = (base + off) % NUM_REQ;
      return sum[ID_W-1:0];
   endfunction

   always_comb begin
      grant_id_out = '0;
      any_out      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_out && req_in[wrap_idx(32'(ptr_in), i)]) begin
            any_out      = 1'b1;
            grant_id_out = wrap_idx(32'(ptr_in), i);
         end
      end
   end

endmodule

// File: rtl/classifier_scheduler.sv
// Shares one SVM classifier between NUM_REQ feature streams with round-robin frame grants.
// Define CLASSIFIER_SCHED_STATS_EN to build per-requester saturating detection counters.
module classifier_scheduler
   import classifier_sched_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int NUM_FEATURES   = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                                clk_in,
   input  logic                                rst_n_in,
   input  logic [NUM_REQ-1:0][FEATURE_W-1:0]   req_data_in,
   input  logic [NUM_REQ-1:0]                  req_valid_in,
   input  logic [NUM_REQ-1:0]                  req_last_in,
   output logic [NUM_REQ-1:0]                  req_ready_out,
   input  logic                                model_loading_in,
   output logic [FEATURE_W-1:0]                feature_data_out,
   output logic                                feature_valid_out,
   output logic                                feature_last_out,
   output logic                                predict_enable_out,
   input  logic                                result_valid_in,
   input  logic                                detected_in,
   output logic                                result_valid_out,
   output logic [$clog2(NUM_REQ)-1:0]          result_id_out,
   output logic                                detected_out,
   output logic                                timeout_out,
   output logic [NUM_REQ-1:0][DET_CNT_W-1:0]   det_count_out
);

   localparam int ID_W   = $clog2(NUM_REQ);
   localparam int BEAT_W = $clog2(NUM_FEATURES);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_FEATURES - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

   sched_state_t      state_q, state_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [ID_W-1:0]   res_id_q, res_id_d;
   logic              res_det_q, res_det_d;
   logic              res_tmo_q, res_tmo_d;

   logic [ID_W-1:0]   arb_id;
   logic              arb_any;
   logic              sel_valid;
   logic              sel_last;
   logic              fwd_last;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req_in       (req_valid_in),
      .ptr_in       (ptr_q),
      .grant_id_out (arb_id),
      .any_out      (arb_any)
   );

   assign sel_valid = req_valid_in[id_q];
   assign sel_last  = req_last_in[id_q];
   assign fwd_last  = sel_last | (beat_q == LAST_BEAT);

   always_comb begin
      state_d            = state_q;
      id_d               = id_q;
      ptr_d              = ptr_q;
      beat_d             = beat_q;
      tmo_d              = '0;
      res_id_d           = res_id_q;
      res_det_d          = res_det_q;
      res_tmo_d          = res_tmo_q;
      req_ready_out      = '0;
      feature_data_out   = '0;
      feature_valid_out  = 1'b0;
      feature_last_out   = 1'b0;
      predict_enable_out = 1'b0;

      case (state_q)
         IDLE: begin
            if (!model_loading_in && arb_any) begin
               id_d    = arb_id;
               beat_d  = '0;
               ptr_d   = (arb_id == LAST_ID) ? '0 : arb_id + 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            predict_enable_out  = 1'b1;
            req_ready_out[id_q] = 1'b1;
            feature_data_out    = req_data_in[id_q];
            feature_valid_out   = sel_valid;
            feature_last_out    = fwd_last;
            if (sel_valid) begin
               if (fwd_last) begin
                  // A forced last with more beats still coming must swallow the tail.
                  state_d = sel_last ? WAIT : DRAIN;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            req_ready_out[id_q] = 1'b1;
            if (sel_valid && sel_last) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (result_valid_in) begin
               res_id_d  = id_q;
               res_det_d = detected_in;
               res_tmo_d = 1'b0;
               state_d   = REPORT;
            end else if (tmo_q == TMO_LAST) begin
               res_id_d  = id_q;
               res_det_d = 1'b0;
               res_tmo_d = 1'b1;
               state_d   = REPORT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         REPORT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         id_q      <= '0;
         ptr_q     <= '0;
         beat_q    <= '0;
         tmo_q     <= '0;
         res_id_q  <= '0;
         res_det_q <= 1'b0;
         res_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         ptr_q     <= ptr_d;
         beat_q    <= beat_d;
         tmo_q     <= tmo_d;
         res_id_q  <= res_id_d;
         res_det_q <= res_det_d;
         res_tmo_q <= res_tmo_d;
      end
   end

   assign result_valid_out = (state_q == REPORT);
   assign result_id_out    = res_id_q;
   assign detected_out     = res_det_q;
   assign timeout_out      = res_tmo_q;

`ifdef CLASSIFIER_SCHED_STATS_EN
   logic [NUM_REQ-1:0][DET_CNT_W-1:0] det_cnt_q, det_cnt_d;

   // Counters move on the same edge that raises result_valid_out.
   always_comb begin
      det_cnt_d = det_cnt_q;
      if (state_q == WAIT && result_valid_in && detected_in) begin
         det_cnt_d[id_q] = sat_inc(det_cnt_q[id_q]);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         det_cnt_q <= '0;
      end else begin
         det_cnt_q <= det_cnt_d;
      end
   end

   assign det_count_out = det_cnt_q;
`else
   assign det_count_out = '0;
`endif

endmodule

// File: tb/tb_classifier_scheduler.sv
// Scoreboard bench for classifier_scheduler: expected beats and reports are queued
// by the stimulus and popped by an independent negedge monitor.
module tb_classifier_scheduler;

   localparam int NUM_REQ = 4;
   localparam int NF      = 16;
   localparam int TMO     = 4096;

   logic                        clk_in = 1'b0;
   logic                        rst_n_in;
   logic [NUM_REQ-1:0][15:0]    req_data_in;
   logic [NUM_REQ-1:0]          req_valid_in;
   logic [NUM_REQ-1:0]          req_last_in;
   logic [NUM_REQ-1:0]          req_ready_out;
   logic                        model_loading_in;
   logic [15:0]                 feature_data_out;
   logic                        feature_valid_out;
   logic                        feature_last_out;
   logic                        predict_enable_out;
   logic                        result_valid_in;
   logic                        detected_in;
   logic                        result_valid_out;
   logic [1:0]                  result_id_out;
   logic                        detected_out;
   logic                        timeout_out;
   logic [NUM_REQ-1:0][15:0]    det_count_out;

   always #5 clk_in = ~clk_in;

   classifier_scheduler #(
      .NUM_REQ        (NUM_REQ),
      .NUM_FEATURES   (NF),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_in             (clk_in),
      .rst_n_in           (rst_n_in),
      .req_data_in        (req_data_in),
      .req_valid_in       (req_valid_in),
      .req_last_in        (req_last_in),
      .req_ready_out      (req_ready_out),
      .model_loading_in   (model_loading_in),
      .feature_data_out   (feature_data_out),
      .feature_valid_out  (feature_valid_out),
      .feature_last_out   (feature_last_out),
      .predict_enable_out (predict_enable_out),
      .result_valid_in    (result_valid_in),
      .detected_in        (detected_in),
      .result_valid_out   (result_valid_out),
      .result_id_out      (result_id_out),
      .detected_out       (detected_out),
      .timeout_out        (timeout_out),
      .det_count_out      (det_count_out)
   );

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } beat_t;

   typedef struct packed {
      logic [1:0] id;
      logic       det;
      logic       tmo;
   } rep_t;

   beat_t expBeats[NUM_REQ][$];
   rep_t  expRep[$];
   int    testsRun    = 0;
   int    testsFailed = 0;
   int    modelCnt[NUM_REQ];
   bit    respEn      = 1'b0;
   int    respDelay   = 20;
   logic  respDet     = 1'b1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushReport(input int id, input logic det, input logic tmo);
      rep_t r;
      r.id  = 2'(id);
      r.det = det;
      r.tmo = tmo;
      expRep.push_back(r);
   endtask

   // Drives one frame on requester r; beats beyond NF are expected to be drained silently.
   task automatic applyStimulus(input int r, input int nBeats, input int lastAt, input logic [15:0] base);
      int cyc;
      for (int i = 1; i <= nBeats; i++) begin
         if (i <= NF) begin
            beat_t b;
            b.data = base + 16'(i);
            b.last = (i == lastAt) || (i == NF);
            expBeats[r].push_back(b);
         end
      end
      for (int i = 1; i <= nBeats; i++) begin
         req_data_in[r]  = base + 16'(i);
         req_valid_in[r] = 1'b1;
         req_last_in[r]  = (i == lastAt);
         cyc = 0;
         do begin
            @(negedge clk_in);
            cyc++;
         end while (!req_ready_out[r] && cyc < 3000);
         if (!req_ready_out[r]) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL ready_timeout: req %0d beat %0d got no ready, expected ready within 3000 cycles", r, i);
            req_valid_in[r] = 1'b0;
            req_last_in[r]  = 1'b0;
            return;
         end
         @(posedge clk_in);
         #1;
      end
      req_valid_in[r] = 1'b0;
      req_last_in[r]  = 1'b0;
   endtask

   task automatic waitReports();
      int cyc;
      cyc = 0;
      while (expRep.size() != 0 && cyc < TMO + 200) begin
         @(posedge clk_in);
         cyc++;
      end
      if (expRep.size() != 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL report_timeout: got %0d reports still pending, expected 0", expRep.size());
         expRep.delete();
      end
      repeat (2) @(posedge clk_in);
      #1;
   endtask

   // Monitor: checks every forwarded beat and every report against the queues.
   always @(negedge clk_in) begin
      if (rst_n_in) begin
         if (req_ready_out != '0) begin
            checkOutput("ready_onehot", 32'($countones(req_ready_out)), 32'd1);
         end
         if (feature_valid_out) begin
            int src;
            src = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (req_ready_out[i]) src = i;
            end
            checkOutput("predict_enable", 32'(predict_enable_out), 32'd1);
            if (src < 0 || expBeats[src].size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL beat_unexpected: got data 0x%0h from src %0d, expected no beat", feature_data_out, src);
            end else begin
               beat_t e;
               e = expBeats[src].pop_front();
               checkOutput("beat_data", 32'(feature_data_out), 32'(e.data));
               checkOutput("beat_last", 32'(feature_last_out), 32'(e.last));
            end
         end
         if (result_valid_out) begin
            if (expRep.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL report_unexpected: got report id %0d, expected none", result_id_out);
            end else begin
               rep_t r;
               r = expRep.pop_front();
               checkOutput("report_id", 32'(result_id_out), 32'(r.id));
               checkOutput("report_det", 32'(detected_out), 32'(r.det));
               checkOutput("report_tmo", 32'(timeout_out), 32'(r.tmo));
               if (r.det && !r.tmo) modelCnt[r.id]++;
               for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CLASSIFIER_SCHED_STATS_EN
                  checkOutput("det_count", 32'(det_count_out[i]), 32'(modelCnt[i]));
`else
                  checkOutput("det_count", 32'(det_count_out[i]), 32'd0);
`endif
               end
            end
         end
      end
   end

   // Classifier model: answers a forwarded last beat after respDelay cycles.
   always begin
      @(negedge clk_in);
      if (respEn && rst_n_in && feature_valid_out && feature_last_out) begin
         repeat (respDelay) @(posedge clk_in);
         #1;
         result_valid_in = 1'b1;
         detected_in     = respDet;
         @(posedge clk_in);
         #1;
         result_valid_in = 1'b0;
         detected_in     = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      testsFailed++;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      rst_n_in         = 1'b0;
      req_data_in      = '0;
      req_valid_in     = '0;
      req_last_in      = '0;
      model_loading_in = 1'b0;
      result_valid_in  = 1'b0;
      detected_in      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) modelCnt[i] = 0;

      repeat (3) @(posedge clk_in);
      #1;
      checkOutput("reset_ctrl", 32'({req_ready_out, feature_valid_out, feature_last_out, predict_enable_out,
                                     result_valid_out, detected_out, timeout_out, result_id_out}), 32'd0);
      checkOutput("reset_data", 32'(feature_data_out), 32'd0);
      checkOutput("reset_det_count", 32'(det_count_out[0] | det_count_out[1] | det_count_out[2] | det_count_out[3]), 32'd0);
      #2 rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;

      // All four requesters hold valid: grants rotate 0,1,2,3 then 0 again.
      respEn = 1'b1; respDelay = 5; respDet = 1'b1;
      pushReport(0, 1'b1, 1'b0);
      pushReport(1, 1'b1, 1'b0);
      pushReport(2, 1'b1, 1'b0);
      pushReport(3, 1'b1, 1'b0);
      pushReport(0, 1'b1, 1'b0);
      fork
         begin
            applyStimulus(0, 4, 4, 16'h0000);
            applyStimulus(0, 4, 4, 16'h0100);
         end
         applyStimulus(1, 4, 4, 16'h1000);
         applyStimulus(2, 4, 4, 16'h2000);
         applyStimulus(3, 4, 4, 16'h3000);
      join
      waitReports();

      // Full 16-beat frame, classifier answers after 20 cycles.
      respDelay = 20; respDet = 1'b1;
      pushReport(0, 1'b1, 1'b0);
      applyStimulus(0, 16, 16, 16'h0A00);
      waitReports();

      // 20-beat frame: last forced on beat 16, beats 17..20 drained.
      respDet = 1'b0;
      pushReport(2, 1'b0, 1'b0);
      applyStimulus(2, 20, 20, 16'h2A00);
      waitReports();

      // No classifier answer: timeout reported exactly TMO cycles after the last beat.
      respEn = 1'b0;
      pushReport(3, 1'b0, 1'b1);
      applyStimulus(3, 2, 2, 16'h3A00);
      n = 0;
      do begin
         @(posedge clk_in);
         #1;
         n++;
      end while (!result_valid_out && n < TMO + 50);
      checkOutput("timeout_latency", 32'(n), 32'(TMO));
      waitReports();

      // Result arriving in the final timeout cycle wins over the timeout.
      pushReport(1, 1'b1, 1'b0);
      applyStimulus(1, 3, 3, 16'h1A00);
      repeat (TMO - 1) @(posedge clk_in);
      #1;
      result_valid_in = 1'b1;
      detected_in     = 1'b1;
      @(posedge clk_in);
      #1;
      result_valid_in = 1'b0;
      detected_in     = 1'b0;
      waitReports();

      // Model upload blocks the grant; re-asserting it mid-frame does not abort the frame.
      respEn = 1'b1; respDelay = 10; respDet = 1'b1;
      model_loading_in = 1'b1;
      req_data_in[1]   = 16'h5001;
      req_valid_in[1]  = 1'b1;
      repeat (5) begin
         @(negedge clk_in);
         checkOutput("loading_no_grant", 32'(req_ready_out), 32'd0);
      end
      @(posedge clk_in);
      #1;
      model_loading_in = 1'b0;
      pushReport(1, 1'b1, 1'b0);
      fork
         applyStimulus(1, 6, 6, 16'h5000);
         begin
            @(negedge clk_in);
            checkOutput("grant_latency", 32'(req_ready_out), 32'd0);
            @(negedge clk_in);
            checkOutput("grant_after_loading", 32'(req_ready_out), 32'b0010);
         end
         begin
            repeat (4) @(posedge clk_in);
            #1;
            model_loading_in = 1'b1;
         end
      join
      waitReports();
      model_loading_in = 1'b0;

      // Asynchronous reset in the middle of a frame.
      begin
         beat_t b;
         b.data = 16'h6000;
         b.last = 1'b0;
         repeat (3) expBeats[3].push_back(b);
      end
      req_data_in[3]  = 16'h6000;
      req_last_in[3]  = 1'b0;
      req_valid_in[3] = 1'b1;
      repeat (4) @(posedge clk_in);
      #3;
      rst_n_in = 1'b0;
      #1;
      checkOutput("async_reset_ctrl", 32'({req_ready_out, feature_valid_out, predict_enable_out, result_valid_out}), 32'd0);
      checkOutput("async_reset_data", 32'(feature_data_out), 32'd0);
      req_valid_in[3] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) modelCnt[i] = 0;
      repeat (2) @(posedge clk_in);
      #2 rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;
      checkOutput("post_reset_det_count", 32'(det_count_out[0] | det_count_out[1] | det_count_out[2] | det_count_out[3]), 32'd0);
      pushReport(3, 1'b1, 1'b0);
      applyStimulus(3, 5, 5, 16'h6100);
      waitReports();

      repeat (5) @(posedge clk_in);
      #1;
      checkOutput("beats_drained", 32'(expBeats[0].size() + expBeats[1].size() + expBeats[2].size() + expBeats[3].size()), 32'd0);
      checkOutput("reports_drained", 32'(expRep.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
